snake_dir_sched: RTL
====================

Name: snake_dir_sched

Overview:
Direction scheduler between the PS/2 keyboard receiver and the snake game engine. Decodes make/break keycodes into direction, pause and restart commands. Buffers direction changes in a small FIFO and applies at most one per game tick, so fast key sequences are not lost. Rejects reversals and typematic repeats.

Parameters:
QDEPTH, 4, direction FIFO depth (power of 2, 2..16)
INIT_DIR, 2'd1, direction after reset/restart (0 up, 1 right, 2 down, 3 left)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
key_valid  in  1  one-cycle strobe: new byte appended to key_code
key_code  in  16  [15:8] previous byte, [7:0] newest byte from PS/2 receiver
tick  in  1  one-cycle game step strobe
dir  out  2  current applied direction
step  out  1  one-cycle strobe: engine advances using dir
restart  out  1  one-cycle restart strobe
paused  out  1  pause state
q_level  out  $clog2(QDEPTH)+1  FIFO occupancy
overflow  out  1  sticky: a direction was dropped because FIFO full; cleared by rst/restart

Behaviour:
- Reset (rst=1 at clk edge): dir=INIT_DIR, step=0, restart=0, paused=0, q_level=0, overflow=0, held key cleared. Reset dominates all other inputs.
- Decode runs only when key_valid=1. If key_code[7:0] is E0 or F0, the byte is a prefix and is ignored.
- Break: key_code[15:8]==F0. If key_code[7:0] equals held_code, clear held. No other effect.
- Make: any other non-prefix byte. Map:
  - 75 or 1D -> up(0)
  - 74 or 23 -> right(1)
  - 72 or 1B -> down(2)
  - 6B or 1C -> left(3)
  - 29 (space) -> pause toggle
  - 76 (esc) -> restart
  - all other codes are ignored.
- Typematic: a make whose byte equals held_code is ignored. Otherwise held_code is set to the new byte, then the action is performed.
- Direction enqueue: ref = FIFO tail if q_level>0, else dir. Drop if new==ref or new==ref^2 (reversal). Drop if FIFO full and set overflow. Otherwise push.
- Pause toggle: paused<=~paused. The queue is preserved.
- Restart: registered restart=1 for one cycle. FIFO flushed, dir=INIT_DIR, paused=0, overflow=0, held cleared.
  - Restart dominates a same-cycle tick: no step in that cycle.
- Tick with paused=0:
  - Next cycle step=1.
  - If q_level>0, pop head into dir in the same edge. step and the new dir are therefore visible together, one cycle after tick.
  - If q_level==0, dir is unchanged.
- Tick with paused=1: no step, no pop.
- Simultaneous push and pop in one cycle: both occur and q_level is unchanged.
  - When full, a simultaneous pop frees the slot, so the push is accepted and overflow is not set.
  - The reversal check uses the pre-pop tail.
- A pause toggle and tick in the same cycle: the tick is evaluated with the old paused value.
- FIFO: circular buffer with rd/wr pointers wrapping modulo QDEPTH. Occupancy counter is the full/empty source.

Decomposition:
- Shared package snake_pkg:
  - direction encoding constants DIR_UP/RIGHT/DOWN/LEFT.
  - scan code constants (SC_E0, SC_F0, SC_UP, SC_DN, SC_LT, SC_RT, SC_W/A/S/D, SC_SPACE, SC_ESC).
  - opposite() function (xor 2).
- One sub-module: snake_dir_fifo. Parameterised QDEPTH x 2-bit synchronous FIFO with push, pop, flush, head, tail, level, full, empty.
- Decode and tick sequencing stay in snake_dir_sched.

Test Plan:
- Reset, then tick -> next cycle step=1, dir=1, q_level=0, paused=0.
- key E0 75, then F0 75, then tick -> q_level 1 after the make. Step cycle shows dir=0, q_level=0.
- dir=1; press left (6B) and release -> dropped, q_level=0. Press up, then left -> both queued; two ticks give dir=0 then 3.
- Repeated make 1D x3 without break -> one entry. Break, then 1D again while tail=up -> dropped as same direction.
- Fill FIFO with alternating up/right x5 (QDEPTH=4) -> q_level=4, overflow=1. Push coincident with a tick at full -> accepted, q_level stays 4.
- Space, then tick -> paused=1, no step. Esc -> restart pulse, paused=0, dir=1, q_level=0, overflow=0. Esc with tick in the same cycle -> no step.

Source files
------------

// File: rtl/snake_pkg.sv
// snake_pkg: shared definitions for the snake direction scheduler.
//   - direction encoding (0 up, 1 right, 2 down, 3 left)
//   - PS/2 set-2 scan codes used by the scheduler
//   - opposite(): reverse of a direction (xor 2)
//   - decode_make(): maps a make byte to a command bundle
package snake_pkg;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  localparam logic [7:0] SC_E0    = 8'hE0;
  localparam logic [7:0] SC_F0    = 8'hF0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DN    = 8'h72;
  localparam logic [7:0] SC_LT    = 8'h6B;
  localparam logic [7:0] SC_RT    = 8'h74;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_ESC   = 8'h76;

  // Decoded action of a single make code.
  typedef struct packed {
    logic       dir_vld;
    logic [1:0] dir;
    logic       pause;
    logic       restart;
  } key_cmd_t;

  function automatic logic [1:0] opposite(input logic [1:0] d);
    return d ^ 2'd2;
  endfunction

  function automatic key_cmd_t decode_make(input logic [7:0] code);
    key_cmd_t c;
    c = '0;
    case (code)
      SC_UP, SC_W: begin c.dir_vld = 1'b1; c.dir = DIR_UP;    end
      SC_RT, SC_D: begin c.dir_vld = 1'b1; c.dir = DIR_RIGHT; end
      SC_DN, SC_S: begin c.dir_vld = 1'b1; c.dir = DIR_DOWN;  end
      SC_LT, SC_A: begin c.dir_vld = 1'b1; c.dir = DIR_LEFT;  end
      SC_SPACE:    c.pause   = 1'b1;
      SC_ESC:      c.restart = 1'b1;
      default:     c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/snake_dir_fifo.sv
// snake_dir_fifo: QDEPTH x 2-bit circular FIFO of pending directions.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   push, din     enqueue din (accepted when not full, or when a pop
//                 happens in the same cycle)
//   pop           dequeue head (ignored when empty)
//   flush         empty the FIFO; dominates push/pop
//   head, tail    oldest / newest entry (valid only when not empty)
//   level         occupancy, 0..QDEPTH
//   full, empty   derived from the occupancy counter
module snake_dir_fifo #(
  parameter int QDEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [1:0]                din,
  input  logic                      pop,
  input  logic                      flush,
  output logic [1:0]                head,
  output logic [1:0]                tail,
  output logic [$clog2(QDEPTH):0]   level,
  output logic                      full,
  output logic                      empty
);

  localparam int PW = $clog2(QDEPTH);

  logic [1:0]    mem_q [QDEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW:0]   level_q, level_d;
  logic          do_push, do_pop;
  logic [PW-1:0] tail_ptr;

  // QDEPTH is a power of two, so the counter MSB alone marks full.
  assign full     = level_q[PW];
  assign empty    = (level_q == '0);
  assign level    = level_q;
  assign tail_ptr = wr_ptr_q - 1'b1;
  assign head     = mem_q[rd_ptr_q];
  assign tail     = mem_q[tail_ptr];

  always_comb begin
    do_push  = push && (!full || (pop && !empty)) && !flush;
    do_pop   = pop && !empty && !flush;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    level_d  = level_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: entries are only read while counted valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/snake_dir_sched.sv
// snake_dir_sched: turns PS/2 make/break bytes into snake commands.
// Direction keys are queued and applied one per unpaused game tick.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   key_valid   strobe: key_code holds {previous byte, newest byte}
//   key_code    [15:8] previous byte, [7:0] newest byte
//   tick        game step strobe
//   dir         currently applied direction
//   step        one cycle after an unpaused tick; engine moves using dir
//   restart     one-cycle pulse after Esc
//   paused      pause state (toggled by Space)
//   q_level     number of queued direction changes
//   overflow    sticky: a direction was lost to a full queue
module snake_dir_sched
  import snake_pkg::*;
#(
  parameter int         QDEPTH   = 4,
  parameter logic [1:0] INIT_DIR = 2'd1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    key_valid,
  input  logic [15:0]             key_code,
  input  logic                    tick,
  output logic [1:0]              dir,
  output logic                    step,
  output logic                    restart,
  output logic                    paused,
  output logic [$clog2(QDEPTH):0] q_level,
  output logic                    overflow
);

  logic [1:0] dir_q, dir_d;
  logic       step_q, step_d;
  logic       restart_q, restart_d;
  logic       paused_q, paused_d;
  logic       overflow_q, overflow_d;
  logic [7:0] held_q, held_d;
  logic       held_vld_q, held_vld_d;

  logic       is_prefix, is_break, is_make, make_new;
  key_cmd_t   cmd;
  logic       tick_ok, pop_eff;
  logic [1:0] ref_dir;
  logic       dir_ok;

  logic       fifo_push, fifo_full, fifo_empty;
  logic [1:0] fifo_head, fifo_tail;

  snake_dir_fifo #(.QDEPTH(QDEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (cmd.dir),
    .pop   (tick_ok),
    .flush (cmd.restart),
    .head  (fifo_head),
    .tail  (fifo_tail),
    .level (q_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    is_prefix = (key_code[7:0] == SC_E0) || (key_code[7:0] == SC_F0);
    is_break  = key_valid && !is_prefix && (key_code[15:8] == SC_F0);
    is_make   = key_valid && !is_prefix && !is_break;
    // A make matching the held key is a typematic repeat.
    make_new  = is_make && !(held_vld_q && (key_code[7:0] == held_q));
    cmd       = make_new ? decode_make(key_code[7:0]) : '0;

    held_d     = held_q;
    held_vld_d = held_vld_q;
    if (is_break && held_vld_q && (key_code[7:0] == held_q)) begin
      held_vld_d = 1'b0;
    end
    if (make_new) begin
      held_d     = key_code[7:0];
      held_vld_d = 1'b1;
    end
    if (cmd.restart) begin
      held_d     = '0;
      held_vld_d = 1'b0;
    end

    // Tick uses the pre-toggle paused value; restart suppresses it.
    tick_ok = tick && !paused_q && !cmd.restart;
    pop_eff = tick_ok && !fifo_empty;

    // Compare against the last direction that will be in effect (pre-pop tail).
    ref_dir   = fifo_empty ? dir_q : fifo_tail;
    dir_ok    = cmd.dir_vld && (cmd.dir != ref_dir) && (cmd.dir != opposite(ref_dir));
    fifo_push = dir_ok && (!fifo_full || pop_eff);

    step_d    = tick_ok;
    restart_d = cmd.restart;

    if (cmd.restart)  dir_d = INIT_DIR;
    else if (pop_eff) dir_d = fifo_head;
    else              dir_d = dir_q;

    if (cmd.restart)    paused_d = 1'b0;
    else if (cmd.pause) paused_d = ~paused_q;
    else                paused_d = paused_q;

    if (cmd.restart) overflow_d = 1'b0;
    else             overflow_d = overflow_q | (dir_ok && fifo_full && !pop_eff);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dir_q      <= INIT_DIR;
      step_q     <= 1'b0;
      restart_q  <= 1'b0;
      paused_q   <= 1'b0;
      overflow_q <= 1'b0;
      held_q     <= '0;
      held_vld_q <= 1'b0;
    end else begin
      dir_q      <= dir_d;
      step_q     <= step_d;
      restart_q  <= restart_d;
      paused_q   <= paused_d;
      overflow_q <= overflow_d;
      held_q     <= held_d;
      held_vld_q <= held_vld_d;
    end
  end

  assign dir      = dir_q;
  assign step     = step_q;
  assign restart  = restart_q;
  assign paused   = paused_q;
  assign overflow = overflow_q;

endmodule
